// File: rtl/mor1kx_spr_pkg.sv
// mor1kx_spr_pkg: shared types and constants for the SPR access responder.
// Group 0 configuration words 0..10 are served locally; every other SPR
// address goes out on the shared SPR bus.
package mor1kx_spr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCAL,
      ST_BUS,
      ST_RESP
   } spr_state_t;

   // Group 0 configuration register indices
   localparam int SPR_VR_IDX       = 0;
   localparam int SPR_UPR_IDX      = 1;
   localparam int SPR_CPUCFGR_IDX  = 2;
   localparam int SPR_DMMUCFGR_IDX = 3;
   localparam int SPR_IMMUCFGR_IDX = 4;
   localparam int SPR_DCCFGR_IDX   = 5;
   localparam int SPR_ICCFGR_IDX   = 6;
   localparam int SPR_DCFGR_IDX    = 7;
   localparam int SPR_PCCFGR_IDX   = 8;
   localparam int SPR_VR2_IDX      = 9;
   localparam int SPR_AVR_IDX      = 10;

   localparam int SPR_LOCAL_MAX    = 10;
   localparam int SPR_CFG_WORDS    = SPR_LOCAL_MAX + 1;

   localparam int SPR_GROUP_MSB    = 15;
   localparam int SPR_GROUP_LSB    = 11;

   // True when the address names a locally served group 0 config word
   function automatic logic spr_is_local(input logic [15:0] addr);
      return (addr[SPR_GROUP_MSB:SPR_GROUP_LSB] == '0) &&
             (addr[SPR_GROUP_LSB-1:0] <= 11'(SPR_LOCAL_MAX));
   endfunction

endpackage

// File: rtl/mor1kx_spr_timer.sv
// mor1kx_spr_timer: 8-bit bus wait counter. Cleared while no bus access is
// in flight, counts each bus cycle without an ack, and flags expiry when the
// count reaches OPTION_SPR_TIMEOUT-1 (the last strobe cycle allowed).
module mor1kx_spr_timer #(
   parameter int OPTION_SPR_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] count;

   // Wait counter: clear has priority over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 8'd1;
   end

   assign expired = (count == 8'(OPTION_SPR_TIMEOUT - 1));

endmodule

// File: rtl/mor1kx_spr_access.sv
// mor1kx_spr_access: l.mfspr / l.mtspr responder. Group 0 config words are
// answered locally; all other SPRs use the strobe/ack SPR bus.
// Optional feature macro: MOR1KX_SPR_BUS_TIMEOUT_EN (bus wait timeout with
// error response). Without it the bus waits forever and err_o is tied 0.
module mor1kx_spr_access
   import mor1kx_spr_pkg::*;
#(
   parameter int OPTION_SPR_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [15:0]   addr_i,
   input  logic [31:0]   wdata_i,
   output logic          ack_o,
   output logic [31:0]   rdata_o,
   output logic          err_o,
   input  logic [351:0]  spr_cfg_i,
   output logic          spr_bus_stb_o,
   output logic          spr_bus_we_o,
   output logic [15:0]   spr_bus_addr_o,
   output logic [31:0]   spr_bus_dat_o,
   input  logic [31:0]   spr_bus_dat_i,
   input  logic          spr_bus_ack_i
);

   spr_state_t  state;
   logic        acc_we;
   logic [15:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [31:0] cfg_word;
   logic        timeout;

   // The bus sees the access as latched in IDLE, so mid-access input
   // changes cannot leak out.
   assign spr_bus_we_o   = acc_we;
   assign spr_bus_addr_o = acc_addr;
   assign spr_bus_dat_o  = acc_wdata;

`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
   mor1kx_spr_timer #(
      .OPTION_SPR_TIMEOUT(OPTION_SPR_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != ST_BUS),
      .en      ((state == ST_BUS) && !spr_bus_ack_i),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Select the config word named by the latched index (only 0..10 reach LOCAL)
   always_comb begin
      cfg_word = '0;
      for (int k = 0; k < SPR_CFG_WORDS; k++)
         if (acc_addr[3:0] == 4'(k))
            cfg_word = spr_cfg_i[32*k +: 32];
   end

   // Access FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         acc_we        <= 1'b0;
         acc_addr      <= '0;
         acc_wdata     <= '0;
         ack_o         <= 1'b0;
         rdata_o       <= '0;
         spr_bus_stb_o <= 1'b0;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
         err_o         <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_i) begin
                  acc_we    <= we_i;
                  acc_addr  <= addr_i;
                  acc_wdata <= wdata_i;
                  if (spr_is_local(addr_i)) begin
                     state <= ST_LOCAL;
                  end else begin
                     state         <= ST_BUS;
                     spr_bus_stb_o <= 1'b1;
                  end
               end
            end
            ST_LOCAL: begin
               // Config words are read-only: writes vanish and read back 0
               rdata_o <= acc_we ? 32'd0 : cfg_word;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
               err_o   <= 1'b0;
`endif
               ack_o   <= 1'b1;
               state   <= ST_RESP;
            end
            ST_BUS: begin
               // A bus ack in the expiry cycle takes precedence over timeout
               if (spr_bus_ack_i) begin
                  spr_bus_stb_o <= 1'b0;
                  rdata_o       <= acc_we ? 32'd0 : spr_bus_dat_i;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
                  err_o         <= 1'b0;
`endif
                  ack_o         <= 1'b1;
                  state         <= ST_RESP;
               end else if (timeout) begin
                  spr_bus_stb_o <= 1'b0;
                  rdata_o       <= '0;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
                  err_o         <= 1'b1;
`endif
                  ack_o         <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               ack_o <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mor1kx_spr_access.sv
// tb_mor1kx_spr_access: directed bench for the SPR access responder.
// Latency counts cycles from the request cycle N (lat 2 == ack in N+2).
module tb_mor1kx_spr_access;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [15:0]   addr_i = '0;
   logic [31:0]   wdata_i = '0;
   logic          ack_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic [351:0]  spr_cfg_i;
   logic          spr_bus_stb_o;
   logic          spr_bus_we_o;
   logic [15:0]   spr_bus_addr_o;
   logic [31:0]   spr_bus_dat_o;
   logic [31:0]   spr_bus_dat_i = '0;
   logic          spr_bus_ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   // Per-access observations
   int          lat, stbs;
   logic        got;
   logic [31:0] rd;
   logic        er;
   logic [15:0] b_addr;
   logic        b_we;
   logic [31:0] b_dat;

   mor1kx_spr_access #(.OPTION_SPR_TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_i          (req_i),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .ack_o          (ack_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .spr_cfg_i      (spr_cfg_i),
      .spr_bus_stb_o  (spr_bus_stb_o),
      .spr_bus_we_o   (spr_bus_we_o),
      .spr_bus_addr_o (spr_bus_addr_o),
      .spr_bus_dat_o  (spr_bus_dat_o),
      .spr_bus_dat_i  (spr_bus_dat_i),
      .spr_bus_ack_i  (spr_bus_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Issue one access and act as bus slave: ack in the ack_after-th strobe
   // cycle (0 = never) returning bdat. Gives up after max_cyc cycles.
   task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input int ack_after, input logic [31:0] bdat, input int max_cyc);
      lat = 0; stbs = 0; got = 1'b0; rd = '0; er = 1'b0;
      b_addr = '0; b_we = 1'b0; b_dat = '0;
      @(negedge clk);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      for (int c = 1; c <= max_cyc && !got; c++) begin
         @(negedge clk);
         spr_bus_ack_i = 1'b0;
         if (ack_o) begin
            got = 1'b1; lat = c; rd = rdata_o; er = err_o;
         end
         if (spr_bus_stb_o) begin
            stbs++;
            b_addr = spr_bus_addr_o; b_we = spr_bus_we_o; b_dat = spr_bus_dat_o;
            if (stbs == ack_after) begin
               spr_bus_ack_i = 1'b1;
               spr_bus_dat_i = bdat;
            end
         end
      end
      req_i = 1'b0; spr_bus_ack_i = 1'b0;
      we_i = 1'b0; addr_i = 16'hFFFF; wdata_i = 32'h5555_5555;
   endtask

   initial begin
      for (int k = 0; k < 11; k++)
         spr_cfg_i[32*k +: 32] = 32'hA000_0000 | 32'(k);
      spr_cfg_i[32*2 +: 32] = 32'h0000_0620;

      // Reset state
      #12;
      chk("rst_ack",  {31'd0, ack_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err",  {31'd0, err_o}, 32'd0);
      chk("rst_stb",  {31'd0, spr_bus_stb_o}, 32'd0);
      chk("rst_baddr", {16'd0, spr_bus_addr_o}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Local read of CPUCFGR
      access(1'b0, 16'h0002, 32'h0, 0, 32'h0, 10);
      chk("lrd_got", {31'd0, got}, 32'd1);
      chk("lrd_lat", 32'(lat), 32'd2);
      chk("lrd_data", rd, 32'h0000_0620);
      chk("lrd_stb", 32'(stbs), 32'd0);
      // Read data holds after the access
      repeat (3) @(negedge clk);
      chk("lrd_hold", rdata_o, 32'h0000_0620);

      // Local write is discarded
      access(1'b1, 16'h0001, 32'hDEAD_BEEF, 0, 32'h0, 10);
      chk("lwr_lat", 32'(lat), 32'd2);
      chk("lwr_data", rd, 32'd0);
      chk("lwr_stb", 32'(stbs), 32'd0);
      access(1'b0, 16'h0001, 32'h0, 0, 32'h0, 10);
      chk("lwr_readback", rd, 32'hA000_0001);

      // Last local index
      access(1'b0, 16'h000A, 32'h0, 0, 32'h0, 10);
      chk("avr_lat", 32'(lat), 32'd2);
      chk("avr_data", rd, 32'hA000_000A);

      // Group 0 index 11 is not local
      access(1'b0, 16'h000B, 32'h0, 1, 32'hCAFE_0011, 10);
      chk("idx11_stb", 32'(stbs), 32'd1);
      chk("idx11_addr", {16'd0, b_addr}, 32'h0000_000B);
      chk("idx11_data", rd, 32'hCAFE_0011);

      // Bus read, ack in third strobe cycle
      access(1'b0, 16'h4800, 32'h0, 3, 32'h1234_5678, 20);
      chk("brd_stb", 32'(stbs), 32'd3);
      chk("brd_lat", 32'(lat), 32'd4);
      chk("brd_data", rd, 32'h1234_5678);
      chk("brd_err", {31'd0, er}, 32'd0);
      chk("brd_stb_after", {31'd0, spr_bus_stb_o}, 32'd0);

      // Bus write, ack in first strobe cycle
      access(1'b1, 16'h2803, 32'h0BAD_F00D, 1, 32'hFFFF_FFFF, 10);
      chk("bwr_lat", 32'(lat), 32'd2);
      chk("bwr_addr", {16'd0, b_addr}, 32'h0000_2803);
      chk("bwr_we", {31'd0, b_we}, 32'd1);
      chk("bwr_dat", b_dat, 32'h0BAD_F00D);
      chk("bwr_rdata", rd, 32'd0);

`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
      // Timeout after 4 strobe cycles
      access(1'b0, 16'h5000, 32'h0, 0, 32'h0, 20);
      chk("to_got", {31'd0, got}, 32'd1);
      chk("to_stb", 32'(stbs), 32'd4);
      chk("to_lat", 32'(lat), 32'd5);
      chk("to_err", {31'd0, er}, 32'd1);
      chk("to_rdata", rd, 32'd0);
      // Ack in the expiry cycle wins
      access(1'b0, 16'h5000, 32'h0, 4, 32'h0000_7777, 20);
      chk("to4_stb", 32'(stbs), 32'd4);
      chk("to4_lat", 32'(lat), 32'd5);
      chk("to4_err", {31'd0, er}, 32'd0);
      chk("to4_rdata", rd, 32'h0000_7777);
`else
      // No timeout: a slow slave is waited for
      access(1'b0, 16'h5000, 32'h0, 10, 32'h0000_9999, 30);
      chk("slow_stb", 32'(stbs), 32'd10);
      chk("slow_lat", 32'(lat), 32'd11);
      chk("slow_err", {31'd0, er}, 32'd0);
      chk("slow_rdata", rd, 32'h0000_9999);
`endif

      // Reset in the middle of a bus access
      access(1'b0, 16'h6000, 32'h0, 0, 32'h0, 2);
      chk("mid_stb_before", {31'd0, spr_bus_stb_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_stb_rst", {31'd0, spr_bus_stb_o}, 32'd0);
      chk("mid_ack_rst", {31'd0, ack_o}, 32'd0);
      chk("mid_rdata_rst", rdata_o, 32'd0);
      spr_bus_ack_i = 1'b1; spr_bus_dat_i = 32'hBBBB_BBBB;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); spr_bus_ack_i = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ack_o || spr_bus_stb_o) got = 1'b1;
      end
      chk("mid_quiet", {31'd0, got}, 32'd0);
      access(1'b0, 16'h0002, 32'h0, 0, 32'h0, 10);
      chk("post_rst_lat", 32'(lat), 32'd2);
      chk("post_rst_data", rd, 32'h0000_0620);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
